// File: rtl/ft_host_pkg.sv
// Shared constants, state encoding and packet builder for the FT2232 host-side initiator.
package ft_host_pkg;

  localparam logic [7:0] CMD_MAGIC = 8'hAA;
  localparam logic [7:0] RSP_MAGIC = 8'hAB;

  localparam int unsigned CMD_BYTES = 8;
  localparam int unsigned RSP_BYTES = 5;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    RECV,
    DONE
  } state_e;

  // Byte 0 sits in bits [7:0] so the packet can be shifted out LSB-first.
  function automatic logic [63:0] build_cmd(input logic        write,
                                            input logic [15:0] addr,
                                            input logic [31:0] data);
    return {data, addr, 7'b0, write, CMD_MAGIC};
  endfunction

endpackage

// File: rtl/ft_strobe_edge.sv
// Registers an asynchronous strobe twice and reports a one-cycle edge pulse.
module ft_strobe_edge #(
  parameter bit FallEdge = 1'b0
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic strobe_i,
  output logic pulse_o
);

  logic strobe_q;
  logic strobe_prev_q;

  // Both strobes idle high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      strobe_q      <= 1'b1;
      strobe_prev_q <= 1'b1;
    end else begin
      strobe_q      <= strobe_i;
      strobe_prev_q <= strobe_q;
    end
  end

  assign pulse_o = FallEdge ? (~strobe_q & strobe_prev_q) : (strobe_q & ~strobe_prev_q);

endmodule

// File: rtl/ft_host_initiator.sv
// Host-side end of the FT2232 async-FIFO link: sends 8-byte command packets to host_iface
// and collects its 5-byte reply.
module ft_host_initiator
  import ft_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 1
) (
  input  logic        clk_i,
  input  logic        nreset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        nrxf_o,
  input  logic        nrd_i,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  output logic        ntxe_o,
  input  logic        wr_i,
  input  logic [7:0]  d_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [2:0] CmdLast = 3'(CMD_BYTES - 1);

  state_e          state_q;
  logic [63:0]     buf_q;
  logic [2:0]      idx_q;
  logic [TmoW-1:0] tmo_q;
  logic [GapW-1:0] gap_q;
  logic            err_q;
  logic [23:0]     rx_data_q;
  logic [7:0]      d_in_q;
  logic            nrxf_q;
  logic            ntxe_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [31:0]     rsp_data_q;

  logic nrd_rise;
  logic wr_fall;
  logic counting;
  logic byte_evt;
  logic tmo_abort;

  ft_strobe_edge #(
    .FallEdge(1'b0)
  ) u_nrd_edge (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .strobe_i(nrd_i),
    .pulse_o (nrd_rise)
  );

  ft_strobe_edge #(
    .FallEdge(1'b1)
  ) u_wr_edge (
    .clk_i   (clk_i),
    .nreset_i(nreset_i),
    .strobe_i(wr_i),
    .pulse_o (wr_fall)
  );

  // Reply byte is registered alongside wr so it lines up with the detected fall.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      d_in_q <= 8'h00;
    end else begin
      d_in_q <= d_i;
    end
  end

  // Strobes in the wrong phase are ignored so they neither advance nor refresh the timeout.
  always_comb begin
    counting  = (state_q == SEND) || (state_q == GAP) || (state_q == RECV);
    byte_evt  = ((state_q == SEND) && nrd_rise) || ((state_q == RECV) && wr_fall);
    tmo_abort = counting && !byte_evt && (tmo_q == TmoLast);
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      rx_data_q   <= '0;
      nrxf_q      <= 1'b1;
      ntxe_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (counting) begin
        tmo_q <= byte_evt ? '0 : tmo_q + 1'b1;
      end

      if (tmo_abort) begin
        state_q     <= DONE;
        buf_q       <= '0;
        nrxf_q      <= 1'b1;
        ntxe_q      <= 1'b1;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_data_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cmd_valid_i) begin
              buf_q   <= build_cmd(cmd_write_i, cmd_addr_i, cmd_data_i);
              idx_q   <= '0;
              tmo_q   <= '0;
              err_q   <= 1'b0;
              nrxf_q  <= 1'b0;
              state_q <= SEND;
            end
          end
          SEND: begin
            if (nrd_rise) begin
              // Zero-filled shift leaves the buffer (and d_o) clear after the last byte.
              buf_q  <= {8'h00, buf_q[63:8]};
              nrxf_q <= 1'b1;
              if (idx_q == CmdLast) begin
                idx_q   <= '0;
                ntxe_q  <= 1'b0;
                state_q <= RECV;
              end else begin
                idx_q   <= idx_q + 3'd1;
                gap_q   <= '0;
                state_q <= GAP;
              end
            end
          end
          GAP: begin
            if (gap_q == GapLast) begin
              nrxf_q  <= 1'b0;
              state_q <= SEND;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
          RECV: begin
            if (wr_fall) begin
              idx_q <= idx_q + 3'd1;
              case (idx_q)
                3'd0:    err_q <= (d_in_q != RSP_MAGIC);
                3'd1:    rx_data_q[7:0]   <= d_in_q;
                3'd2:    rx_data_q[15:8]  <= d_in_q;
                3'd3:    rx_data_q[23:16] <= d_in_q;
                default: begin
                  ntxe_q      <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= err_q;
                  rsp_data_q  <= {d_in_q, rx_data_q};
                  state_q     <= DONE;
                end
              endcase
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign nrxf_o      = nrxf_q;
  assign ntxe_o      = ntxe_q;
  assign d_o         = buf_q[7:0];
  assign d_oe_o      = (state_q == SEND) && !nrd_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_ft_host_initiator.sv
// Directed bench: emulates host_iface plus a tiny register bank around ft_host_initiator.
module tb_ft_host_initiator;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        nrxf;
  logic        nrd = 1'b1;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        ntxe;
  logic        wr = 1'b1;
  logic [7:0]  d_in = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  int acc_cyc = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;

  logic [7:0]  rx_cmd [8];
  logic [31:0] reg1 = '0;

  always #5 clk = ~clk;

  ft_host_initiator #(
    .TIMEOUT_CYCLES(16),
    .GAP_CYCLES    (2)
  ) dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_write_i(cmd_write),
    .cmd_addr_i (cmd_addr),
    .cmd_data_i (cmd_data),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .nrxf_o     (nrxf),
    .nrd_i      (nrd),
    .d_o        (d_out),
    .d_oe_o     (d_oe),
    .ntxe_o     (ntxe),
    .wr_i       (wr),
    .d_i        (d_in)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rsp_valid) begin
      rsp_cnt   = rsp_cnt + 1;
      rsp_cyc   = cyc;
      last_data = rsp_data;
      last_err  = rsp_err;
    end
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_nrxf(input logic lvl);
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (nrxf === lvl) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_nrxf", nrxf, lvl);
  endtask

  task automatic wait_ntxe_low();
    bit ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ntxe === 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_ntxe", ntxe, 0);
  endtask

  task automatic wait_rsp(input int prev);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (rsp_cnt != prev) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_rsp", rsp_cnt, prev + 1);
  endtask

  task automatic get_cmd(input int n);
    for (int i = 0; i < n; i++) begin
      wait_nrxf(1'b0);
      @(posedge clk);
      #1 nrd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("d_oe_during_nrd", d_oe, 1);
      rx_cmd[i] = d_out;
      @(posedge clk);
      #1 nrd = 1'b1;
      wait_nrxf(1'b1);
    end
  endtask

  task automatic send_rsp(input logic [39:0] bytes);
    wait_ntxe_low();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 d_in = bytes[i*8 +: 8];
      @(posedge clk);
      #1 wr = 1'b0;
      repeat (2) @(posedge clk);
      #1 wr = 1'b1;
    end
  endtask

  // host_iface stand-in: reg 1 is read/write, reg 2 is read-only 0xFEEDBEEF.
  task automatic serve();
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] val;
    get_cmd(8);
    a  = {rx_cmd[3], rx_cmd[2]};
    wd = {rx_cmd[7], rx_cmd[6], rx_cmd[5], rx_cmd[4]};
    if (rx_cmd[1] == 8'h01 && a == 16'h0001) reg1 = wd;
    val = (a == 16'h0002) ? 32'hFEEDBEEF : (a == 16'h0001) ? reg1 : 32'h0;
    send_rsp({val, 8'hAB});
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_bytes [8];
    int prev;
    exp_bytes = '{8'hAA, 8'h01, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_nrxf", nrxf, 1);
    chk("rst_ntxe", ntxe, 1);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_d_o", d_out, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback write then read of reg 1
    prev = rsp_cnt;
    issue(1'b1, 16'h0001, 32'hDEADBEEF);
    chk("wr_busy", busy, 1);
    chk("wr_cmd_ready", cmd_ready, 0);
    serve();
    for (int i = 0; i < 8; i++) chk($sformatf("wr_byte%0d", i), rx_cmd[i], exp_bytes[i]);
    wait_rsp(prev);
    chk("wr_err", last_err, 0);
    chk("wr_data", last_data, 32'hDEADBEEF);

    prev = rsp_cnt;
    issue(1'b0, 16'h0001, 32'h0);
    serve();
    chk("rd_byte1", rx_cmd[1], 8'h00);
    wait_rsp(prev);
    chk("rd_err", last_err, 0);
    chk("rd_data", last_data, 32'hDEADBEEF);

    // Write to the read-only register returns its fixed value
    prev = rsp_cnt;
    issue(1'b1, 16'h0002, 32'h0000FFFF);
    serve();
    wait_rsp(prev);
    chk("ro_err", last_err, 0);
    chk("ro_data", last_data, 32'hFEEDBEEF);

    // Bad reply magic still collects all data bytes
    prev = rsp_cnt;
    issue(1'b0, 16'h0005, 32'h0);
    get_cmd(8);
    send_rsp({8'h44, 8'h33, 8'h22, 8'h11, 8'hAC});
    wait_rsp(prev);
    chk("bad_err", last_err, 1);
    chk("bad_data", last_data, 32'h44332211);
    repeat (6) @(negedge clk);
    chk("bad_pulses", rsp_cnt, prev + 1);

    // Timeout: nrd never asserted
    prev = rsp_cnt;
    issue(1'b0, 16'h0003, 32'h0);
    chk("tmo_d_oe_idle", d_oe, 0);
    wait_rsp(prev);
    chk("tmo_latency", rsp_cyc - acc_cyc - 1, 16);
    chk("tmo_err", last_err, 1);
    chk("tmo_data", last_data, 0);
    chk("tmo_nrxf", nrxf, 1);
    chk("tmo_ntxe", ntxe, 1);
    repeat (4) @(negedge clk);
    chk("tmo_pulses", rsp_cnt, prev + 1);

    // Reset in the middle of a packet
    prev = rsp_cnt;
    issue(1'b0, 16'h0001, 32'h0);
    get_cmd(3);
    nreset = 1'b0;
    #1;
    chk("mid_rst_nrxf", nrxf, 1);
    chk("mid_rst_ntxe", ntxe, 1);
    chk("mid_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_cnt, prev);
    issue(1'b0, 16'h0001, 32'h0);
    serve();
    wait_rsp(prev);
    chk("after_rst_err", last_err, 0);
    chk("after_rst_data", last_data, 32'hDEADBEEF);

    // Back-to-back with cmd_valid held high
    prev = rsp_cnt;
    @(posedge clk);
    #1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0001;
    cmd_data  = 32'h12345678;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0002;
    cmd_data  = 32'h0;
    serve();
    wait_rsp(prev);
    chk("b2b_first_err", last_err, 0);
    chk("b2b_first_data", last_data, 32'h12345678);
    prev = rsp_cnt;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (busy) break;
    end
    cmd_valid = 1'b0;
    chk("b2b_accept_cycle", acc_cyc - rsp_cyc, 1);
    serve();
    wait_rsp(prev);
    chk("b2b_second_err", last_err, 0);
    chk("b2b_second_data", last_data, 32'hFEEDBEEF);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
